// File: rtl/booth_seq_mult.sv
// ---------------------------------------------------------------------------
// booth_seq_mult
//
// Iterative radix-4 Booth multiplier. One Booth digit (one partial product)
// is retired per clock into a shifting accumulator, trading latency for area.
// Digit selection is the five-way -2A/-A/0/+A/+2A scheme; negative digits are
// formed by inverting the magnitude and injecting a carry-in of 1 into the
// same adder, so there is no separate negation stage.
//
// Optional feature macro: BOOTH_UNSIGNED_EN
//   When defined, input tc selects signed (tc=1) or unsigned (tc=0)
//   operands. Unsigned operation needs one extra digit.
//
// Parameters:
//   WIDTH   operand width, even and >= 4
//   CNT_W   digit counter width (derived, do not override)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    request, sampled only in IDLE
//   a, b     multiplicand / multiplier, captured on an accepted start
//   tc       (BOOTH_UNSIGNED_EN only) 1 = signed, 0 = unsigned
//   busy     high in RUN and DONE
//   done     one-cycle pulse, product valid
//   product  2*WIDTH result, held until the next DONE entry or reset
//
// State | meaning
//   IDLE  | waiting for start
//   RUN   | retiring one Booth digit per clock; one final cycle after the
//         | last digit moves the result into product
//   DONE  | done pulse, product valid
// ---------------------------------------------------------------------------
module booth_seq_mult #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH/2+2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef BOOTH_UNSIGNED_EN
    input  logic                 tc,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_seq_mult: WIDTH must be even and >= 4");
        end
    endgenerate

`ifdef BOOTH_UNSIGNED_EN
    // Two spare multiplier bits give the extra all-positive top digit that
    // unsigned operands need.
    localparam int XB = 2;
`else
    localparam int XB = 0;
`endif
    localparam int PP_W  = WIDTH + 2;
    localparam int MR_W  = WIDTH + 1 + XB;
    localparam int ACC_W = 2*WIDTH + 2 + XB;
    localparam int LO_W  = ACC_W - PP_W;

    localparam logic [CNT_W-1:0] NDIG_S = CNT_W'(WIDTH/2);
`ifdef BOOTH_UNSIGNED_EN
    localparam logic [CNT_W-1:0] NDIG_U = CNT_W'(WIDTH/2 + 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_a;
    logic [MR_W-1:0]      r_mr;
    logic [ACC_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;
`ifdef BOOTH_UNSIGNED_EN
    logic                 r_tc;
`endif

    logic                 w_load;
    logic                 w_step;
    logic                 w_finish;
    logic [CNT_W-1:0]     w_ndig;
    logic                 w_a_sign;
    logic [PP_W-1:0]      w_a_ext;
    logic [2:0]           w_dig;
    logic                 w_zero;
    logic                 w_two;
    logic                 w_neg;
    logic [PP_W-1:0]      w_mag;
    logic [PP_W-1:0]      w_upper_sum;
    logic [ACC_W-1:0]     w_acc_next;
    logic [2*WIDTH-1:0]   w_result;

`ifdef BOOTH_UNSIGNED_EN
    assign w_ndig   = r_tc ? NDIG_S : NDIG_U;
    assign w_a_sign = r_tc & r_a[WIDTH-1];
    // Signed runs one digit fewer, so the product sits two bits higher.
    assign w_result = r_tc ? r_acc[2*WIDTH+1:2] : r_acc[2*WIDTH-1:0];
`else
    assign w_ndig   = NDIG_S;
    assign w_a_sign = r_a[WIDTH-1];
    assign w_result = r_acc[2*WIDTH-1:0];
`endif

    assign w_a_ext = {{2{w_a_sign}}, r_a};
    assign w_dig   = r_mr[2:0];

    always_comb begin
        w_zero = 1'b0;
        w_two  = 1'b0;
        w_neg  = 1'b0;
        case (w_dig)
            3'b000, 3'b111: w_zero = 1'b1;
            3'b001, 3'b010: ;
            3'b011:         w_two  = 1'b1;
            3'b100: begin
                w_two = 1'b1;
                w_neg = 1'b1;
            end
            default:        w_neg  = 1'b1;
        endcase
    end

    always_comb begin
        if (w_zero)
            w_mag = '0;
        else if (w_two)
            w_mag = {w_a_ext[PP_W-2:0], 1'b0};
        else
            w_mag = w_a_ext;
    end

    // Invert-plus-carry negation folded into the accumulator adder.
    assign w_upper_sum = r_acc[ACC_W-1 -: PP_W]
                       + (w_mag ^ {PP_W{w_neg}})
                       + {{(PP_W-1){1'b0}}, w_neg};

    // Add into the upper bits, then arithmetic shift right by 2.
    assign w_acc_next = {{2{w_upper_sum[PP_W-1]}}, w_upper_sum, r_acc[LO_W-1:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == w_ndig) begin
                    w_finish = 1'b1;
                    w_next   = DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_mr      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
`ifdef BOOTH_UNSIGNED_EN
            r_tc      <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_a   <= a;
                // Appended zero is the implicit b[-1]; upper spare bits are
                // the unsigned zero extension.
                r_mr  <= {{XB{1'b0}}, b, 1'b0};
                r_acc <= '0;
                r_cnt <= '0;
`ifdef BOOTH_UNSIGNED_EN
                r_tc  <= tc;
`endif
            end
            if (w_step) begin
                r_acc <= w_acc_next;
                r_mr  <= {2'b00, r_mr[MR_W-1:2]};
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish)
                r_product <= w_result;
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booth_seq_mult.sv
module tb_booth_seq_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
`ifdef BOOTH_UNSIGNED_EN
    logic        tc;
`endif
    logic        busy;
    logic        done;
    logic [31:0] product;

    int tests = 0;
    int fails = 0;

    booth_seq_mult #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
`ifdef BOOTH_UNSIGNED_EN
        .tc      (tc),
`endif
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts rising edges until done is seen at the following falling edge.
    task automatic wait_done(output int k, output bit got);
        got = 1'b0;
        k   = 0;
        while (!got && k < 30) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            got = done;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [31:0] exp, input int exp_lat);
        int k;
        bit got;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        wait_done(k, got);
        check({tag, " done_seen"}, 64'(got), 64'd1);
        check({tag, " latency"}, 64'(k), 64'(exp_lat));
        check({tag, " product"}, 64'(product), 64'(exp));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int k;
        int k2;
        bit got;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef BOOTH_UNSIGNED_EN
        tc = 1'b1;
`endif
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst product", 64'(product), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("3x5", 16'd3, 16'd5, 32'h0000000F, 9);
        run_op("-7x6", 16'hFFF9, 16'd6, 32'hFFFFFFD6, 9);
        run_op("min x min", 16'h8000, 16'h8000, 32'h40000000, 9);
        run_op("max x min", 16'h7FFF, 16'h8000, 32'hC0008000, 9);
        run_op("b zero", 16'h1234, 16'h0000, 32'h00000000, 9);
        run_op("-1x-1", 16'hFFFF, 16'hFFFF, 32'h00000001, 9);
        run_op("max x max", 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 9);

        // start during RUN is ignored; held start is taken at the first IDLE edge
        @(negedge clk);
        a = 16'd100;
        b = 16'hFFFD;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        a = 16'd7;
        b = 16'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ign hold product", 64'(product), 64'h3FFF0001);
        wait_done(k2, got);
        k = 4 + k2;
        check("ign done_seen", 64'(got), 64'd1);
        check("ign latency", 64'(k), 64'd9);
        check("ign product", 64'(product), 64'hFFFFFED4);
        @(posedge clk);
        @(negedge clk);
        check("ign idle", 64'(busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("ign accept busy", 64'(busy), 64'd1);
        check("ign old held", 64'(product), 64'hFFFFFED4);
        wait_done(k, got);
        check("ign2 latency", 64'(k), 64'd9);
        check("ign2 product", 64'(product), 64'h00000031);

        // asynchronous reset mid-RUN
        @(negedge clk);
        a = 16'h1234;
        b = 16'h0101;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst busy", 64'(busy), 64'd0);
        check("arst done", 64'(done), 64'd0);
        check("arst product", 64'(product), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("arst no_done", 64'(done), 64'd0);
        end
        run_op("2x3", 16'd2, 16'd3, 32'h00000006, 9);

`ifdef BOOTH_UNSIGNED_EN
        tc = 1'b0;
        run_op("u ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 10);
        tc = 1'b1;
        run_op("s ffff", 16'hFFFF, 16'hFFFF, 32'h00000001, 9);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Parametrised iterative radix-4 Booth multiplier. It retires one Booth digit, i.e. one partial product, per clock.
- It is the sequential successor to the team's 16-bit combinational partial-product generator. It reuses the same five-way digit selection (-2A, -A, 0, +A, +2A) and the same invert-plus-sign-carry negation, but adds operand width generality, an accumulator and a start/done handshake.
- It sits in the datapath wherever area matters more than latency.

Parameters:
- WIDTH, 16, operand width in bits. Must be even and >= 4; elaboration-time error otherwise.
- CNT_W, $clog2(WIDTH/2+2), iteration counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, captured when start is accepted
- b  input  WIDTH  multiplier, captured when start is accepted
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse: product is valid
- product  output  2*WIDTH  result; held stable from done until the next accepted start

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, busy=0, done=0, product=0.
  - Accumulator, operand registers and counter are cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- State IDLE:
  - start=1 at edge t captures a and b.
  - Multiplier register is loaded as {b, 1'b0}; the appended bit is the implicit b[-1]=0.
  - Accumulator and counter are cleared; next state is RUN.
- State RUN, one digit per edge:
  - The digit is taken from the low 3 bits of the multiplier register.
  - Encoding: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - The partial product is WIDTH+2 bits wide, with A sign-extended.
  - Negative digits use the bitwise inverse plus a carry-in of 1 in the same adder. No separate negation stage.
  - The partial product is added into the upper bits of the accumulator, then the accumulator is arithmetic-shifted right by 2.
  - The multiplier register is shifted right by 2.
  - Counter increments. After WIDTH/2 digits the next state is DONE.
- State DONE:
  - done=1 for exactly one cycle; product is loaded from the accumulator on entry.
  - Next state is IDLE unconditionally.
- Latency: start sampled at edge t; done high in the cycle after edge t+WIDTH/2+1. Throughput is one result per WIDTH/2+2 cycles.
- start while busy=1 (RUN or DONE) is ignored and not queued. start may be held high; a new operation begins at the first IDLE edge.
- Arithmetic:
  - Operands are two's complement; the result is the exact signed product.
  - -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2WIDTH-2) is representable; no overflow is possible.
- product never changes except on entry to DONE or on reset.
- Changes on a and b outside the accept edge have no effect.

Optional Feature:
- Macro BOOTH_UNSIGNED_EN.
- When defined:
  - Extra input port tc (1 bit) is added, captured alongside a and b.
  - tc=1 gives the signed behaviour above.
  - tc=0 treats both operands as unsigned. a is zero-extended in the partial product, and b is zero-extended by 2 bits.
  - RUN lasts WIDTH/2+1 digits, so latency is one cycle longer.
- When undefined: the tc port is absent, operation is always signed, and RUN is always WIDTH/2 digits.

Test Plan (WIDTH=16):
- a=3, b=5, one start pulse -> busy rises the next cycle; done high for one cycle at t+9 only; product=0x0000000F.
- a=-7 (0xFFF9), b=6 -> product=0xFFFFFFD6. Then a=0x8000, b=0x8000 -> product=0x40000000.
- a=0x7FFF, b=0x8000 -> product=0xC0008000. b=0 -> product=0; a=0xFFFF, b=0xFFFF (-1*-1) -> product=0x00000001.
- start pulsed again with new operands during RUN -> ignored; first result unchanged; the next start is accepted only after done; product holds its old value until the new done.
- rst asserted asynchronously mid-RUN (between edges) -> busy, done and product go to 0 immediately. A fresh a=2, b=3 after release -> product=6 with nominal latency.
- BOOTH_UNSIGNED_EN defined, tc=0, a=0xFFFF, b=0xFFFF -> product=0xFFFE0001, done at t+10. Same operands with tc=1 -> 0x00000001 at t+9.
